// File: rtl/tx_pkg.sv
// Shared transmitter constants and types.
// Also used by the commutator, so the payload length is defined once here.
package tx_pkg;

  // Channel count. The commutator's request bus is 3 bits wide, so this is fixed.
  localparam int unsigned NCH = 3;

  // Width of one lane in bits.
  localparam int unsigned DATA_W = 8;

  // Bytes per packet. A channel reports ready once it holds this many.
  localparam int unsigned PKT_PAYLOAD_LEN = 9;

  // Per-cycle FIFO operation, encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/chan_fifo.sv
// Single-channel byte FIFO with a registered read port.
// - A read is accepted only when the FIFO is not empty.
//   The popped byte appears on rd_data one cycle after rd_req.
// - A write into a full FIFO is still accepted if a read is accepted in the same
//   cycle, because that read frees a slot.
// - When the FIFO is empty there is no fall-through: a simultaneous write is stored
//   and the read is ignored.
// - wr_drop flags a write that was refused because the FIFO was full.
module chan_fifo
  import tx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              wr_drop
);

  localparam int unsigned PTR_W = CNT_W - 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_acc, rd_acc;
  fifo_op_e          op;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Accept decisions. A read frees a slot in the same cycle it is accepted.
  always_comb begin
    rd_acc  = rd_req & ~empty;
    wr_acc  = wr_en & (~full | rd_acc);
    wr_drop = wr_en & ~wr_acc;
    op      = fifo_op_e'({wr_acc, rd_acc});
  end

  // Next-state for the pointers, the count and the read register.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    unique case (op)
      OpWrite: count_d = count_q + CNT_W'(1);
      OpRead:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset. Reset discards buffered data.
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array. It has no reset, and writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (!arst && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/channel_fifo_bank.sv
// Per-channel input buffering in front of the transmitter commutator.
// - Instantiates one chan_fifo per channel.
// - Slices the wide buses into lanes and decodes input_ready from each count.
// - Optional feature macro: CHBUF_OVF_STATUS_EN.
//   When it is defined, the top level adds sticky overflow flags (ovf) with a
//   per-channel clear (clr_ovf). Otherwise a write into a full FIFO is dropped
//   silently.
module channel_fifo_bank
  import tx_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned READY_THRESH = PKT_PAYLOAD_LEN
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [NCH-1:0]        wr_en,
  input  logic [NCH*DATA_W-1:0] wr_data,
  input  logic [NCH-1:0]        read_req,
  output logic [NCH*DATA_W-1:0] input_data,
`ifdef CHBUF_OVF_STATUS_EN
  output logic [NCH-1:0]        ovf,
  input  logic [NCH-1:0]        clr_ovf,
`endif
  output logic [NCH-1:0]        input_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count [NCH];
  logic [NCH-1:0]   drop;
  logic [NCH-1:0]   full;
  logic [NCH-1:0]   empty;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    chan_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .wr_en   (wr_en[ch]),
      .wr_data (wr_data[ch*DATA_W +: DATA_W]),
      .rd_req  (read_req[ch]),
      .rd_data (input_data[ch*DATA_W +: DATA_W]),
      .count   (count[ch]),
      .full    (full[ch]),
      .empty   (empty[ch]),
      .wr_drop (drop[ch])
    );

    // Decoded from the registered count, so ready follows the accepting edge by one cycle.
    assign input_ready[ch] = (count[ch] >= CNT_W'(READY_THRESH));
  end

  // full and empty are not needed at this level.
  // drop is only used when the overflow flags are built.
  logic unused_fifo_status;
  assign unused_fifo_status = ^{full, empty, drop};

`ifdef CHBUF_OVF_STATUS_EN
  logic [NCH-1:0] ovf_q, ovf_d;

  // Sticky overflow. A set in the same cycle as a clear wins.
  always_comb begin
    ovf_d = drop | (ovf_q & ~clr_ovf);
  end

  // Overflow flag register with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
